// File: rtl/button_reader.sv
// Debounced push-button reader: 2-flop synchronizer, debounce FSM, press/release/long strobes.
// Define BUTTON_READER_LONGPRESS_EN to build the LONG_HELD state, hold counter and LONG_PULSE.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 320000,
  parameter int LONG_CYCLES     = 16000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN,
  output logic       BTN_LEVEL,
  output logic       PRESS_PULSE,
  output logic       RELEASE_PULSE,
  output logic       LONG_PULSE,
  output logic [7:0] PRESS_COUNT,
  output logic       LED,
  output logic       USBPU
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
      $error("button_reader: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
`ifdef BUTTON_READER_LONGPRESS_EN
    LONG_HELD    = 3'd3,
`endif
    RELEASE_WAIT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic [7:0]        count_q, count_d;
  logic              led_q, led_d;
  logic              pressed;

`ifdef BUTTON_READER_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              from_long_q, from_long_d;
`endif

  // Button is active-low; only the second synchronizer flop is ever looked at.
  assign pressed = ~sync_q[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= '0;
      led_q       <= 1'b0;
`ifdef BUTTON_READER_LONGPRESS_EN
      hold_cnt_q  <= '0;
      from_long_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], BTN};
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      count_q     <= count_d;
      led_q       <= led_d;
`ifdef BUTTON_READER_LONGPRESS_EN
      hold_cnt_q  <= hold_cnt_d;
      from_long_q <= from_long_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
`ifdef BUTTON_READER_LONGPRESS_EN
    hold_cnt_d  = hold_cnt_q;
    from_long_d = from_long_q;
`endif
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = PRESSED;
`ifdef BUTTON_READER_LONGPRESS_EN
          hold_cnt_d = '0;
`endif
        end else if (db_cnt_q != '1) begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
`ifdef BUTTON_READER_LONGPRESS_EN
          from_long_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = LONG_HELD;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
`ifdef BUTTON_READER_LONGPRESS_EN
      LONG_HELD: begin
        if (!pressed) begin
          state_d     = RELEASE_WAIT;
          db_cnt_d    = '0;
          from_long_d = 1'b1;
        end
      end
`endif
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes the hold where it left off.
        if (pressed) begin
`ifdef BUTTON_READER_LONGPRESS_EN
          state_d = from_long_q ? LONG_HELD : PRESSED;
`else
          state_d = PRESSED;
`endif
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else if (db_cnt_q != '1) begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
    release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
`ifdef BUTTON_READER_LONGPRESS_EN
    long_d    = (state_q == PRESSED) && (state_d == LONG_HELD);
`else
    long_d    = 1'b0;
`endif
    level_d = level_q;
    if (press_d)   level_d = 1'b1;
    if (release_d) level_d = 1'b0;
    count_d = count_q + {7'd0, press_d};
    led_d   = led_q ^ press_d;
  end

  assign BTN_LEVEL     = level_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = release_q;
  assign LONG_PULSE    = long_q;
  assign PRESS_COUNT   = count_q;
  assign LED           = led_q;
  assign USBPU         = 1'b0;

endmodule

// File: tb/tb_button_reader.sv
// Directed testbench for button_reader (DEBOUNCE_CYCLES=8, LONG_CYCLES=32).
// Long-press checks follow BUTTON_READER_LONGPRESS_EN.
module tb_button_reader;
  localparam int D = 8;
  localparam int L = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b1;
  logic       btn_level, press_pulse, release_pulse, long_pulse, led, usbpu;
  logic [7:0] press_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int press_n = 0, rel_n = 0, long_n = 0, multi_n = 0, low_lvl_n = 0;
  int press_at = 0, rel_at = 0, long_at = 0;

  button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .CLK(clk), .RST_N(rst_n), .BTN(btn),
    .BTN_LEVEL(btn_level), .PRESS_PULSE(press_pulse), .RELEASE_PULSE(release_pulse),
    .LONG_PULSE(long_pulse), .PRESS_COUNT(press_count), .LED(led), .USBPU(usbpu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: cyc here is the index of the rising edge that produced the value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (press_pulse)   begin press_n++; press_at = cyc; end
      if (release_pulse) begin rel_n++;   rel_at = cyc;   end
      if (long_pulse)    begin long_n++;  long_at = cyc;  end
      if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1) multi_n++;
      if (!btn_level) low_lvl_n++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    int k, r, p0, r0, l0, lv0, dl;

    // Reset state
    #2;
    check("rst_level", btn_level, 0);
    check("rst_press", press_pulse, 0);
    check("rst_release", release_pulse, 0);
    check("rst_long", long_pulse, 0);
    check("rst_count", press_count, 0);
    check("rst_led", led, 0);
    check("rst_usbpu", usbpu, 0);
    step(3);
    rst_n = 1'b1;
    step(3);

    // Clean press then release
    p0 = press_n; r0 = rel_n; l0 = long_n;
    k = cyc; btn = 1'b0;
    step(15);
    check("a_level_hi", btn_level, 1);
    step(5);
    r = cyc; btn = 1'b1;
    step(20);
    check("a_press_n", press_n - p0, 1);
    check("a_press_at", press_at, k + 11);
    check("a_rel_n", rel_n - r0, 1);
    check("a_rel_at", rel_at, r + 11);
    check("a_count", press_count, 1);
    check("a_led", led, 1);
    check("a_level_lo", btn_level, 0);
    check("a_long_n", long_n - l0, 0);

    // Debounce boundary: 8 low cycles rejected, 9 accepted
    p0 = press_n;
    btn = 1'b0; step(8); btn = 1'b1; step(12);
    check("b_short8", press_n - p0, 0);
    r0 = rel_n;
    k = cyc; btn = 1'b0; step(9); btn = 1'b1; step(14);
    check("b_press9", press_n - p0, 1);
    check("b_press9_at", press_at, k + 11);
    check("b_rel9_at", rel_at, k + 20);
    check("b_rel9_n", rel_n - r0, 1);

    // Bouncing input toggled every 3 cycles
    do_reset();
    p0 = press_n; r0 = rel_n; l0 = long_n;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn = ~btn;
      step(1);
    end
    btn = 1'b1;
    step(12);
    check("c_press_n", press_n - p0, 0);
    check("c_rel_n", rel_n - r0, 0);
    check("c_long_n", long_n - l0, 0);
    check("c_level", btn_level, 0);
    check("c_count", press_count, 0);

    // Long hold
    do_reset();
    p0 = press_n; r0 = rel_n; l0 = long_n;
    k = cyc; btn = 1'b0;
    step(60);
    check("d_press_n", press_n - p0, 1);
    check("d_press_at", press_at, k + 11);
    check("d_level", btn_level, 1);
`ifdef BUTTON_READER_LONGPRESS_EN
    check("d_long_n", long_n - l0, 1);
    check("d_long_at", long_at, press_at + 32);
`else
    check("d_long_n", long_n - l0, 0);
`endif
    btn = 1'b1;
    step(14);
    check("d_rel_n", rel_n - r0, 1);
    check("d_level_lo", btn_level, 0);

    // Short release glitch while pressed
    do_reset();
    p0 = press_n; l0 = long_n;
    btn = 1'b0;
    step(20);
    r0 = rel_n; lv0 = low_lvl_n;
    btn = 1'b1; step(4); btn = 1'b0;
    step(40);
    check("e_press_n", press_n - p0, 1);
    check("e_rel_n", rel_n - r0, 0);
    check("e_level_held", low_lvl_n - lv0, 0);
`ifdef BUTTON_READER_LONGPRESS_EN
    dl = long_at - press_at;
    check("e_long_n", long_n - l0, 1);
    check("e_long_window", int'(dl >= 32 && dl <= 40), 1);
`else
    dl = 0;
    check("e_long_n", long_n - l0, 0);
`endif
    btn = 1'b1;
    step(14);

    // Reset in the middle of a press with the button still held
    do_reset();
    btn = 1'b0;
    step(20);
    check("f_level_pre", btn_level, 1);
    r0 = rel_n;
    #2;
    rst_n = 1'b0;
    #1;
    check("f_async_level", btn_level, 0);
    check("f_async_count", press_count, 0);
    check("f_async_led", led, 0);
    check("f_async_pulses", int'(press_pulse | release_pulse | long_pulse), 0);
    step(3);
    p0 = press_n;
    r = cyc; rst_n = 1'b1;
    step(14);
    check("f_press_n", press_n - p0, 1);
    check("f_press_at", press_at, r + 11);
    check("f_rel_n", rel_n - r0, 0);
    check("f_count", press_count, 1);
    check("f_led", led, 1);
    btn = 1'b1;
    step(14);

    // 256 clean presses wrap the counter
    do_reset();
    p0 = press_n; r0 = rel_n;
    for (int i = 0; i < 256; i++) begin
      btn = 1'b0; step(12);
      btn = 1'b1; step(12);
      if (i == 254) check("g_count255", press_count, 255);
    end
    check("g_press_n", press_n - p0, 256);
    check("g_rel_n", rel_n - r0, 256);
    check("g_count_wrap", press_count, 0);
    check("g_led", led, 0);

    check("one_hot_pulses", multi_n, 0);
    check("usbpu", usbpu, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
